pll_clk_supervisor: RTL

- Downstream companion to the 50 MHz→1.2 MHz PLL wrapper; runs on the free-running 50 MHz reference clock.
- Qualifies the PLL `locked` output with a filter and checks the frequency of `outclk_0` by edge counting.
- Generates the PLL reset request and a held system reset for GeekCounter logic.
- Counts lock-loss events for debug.

---
 rtl/pll_clk_supervisor.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pll_clk_supervisor.sv
// rtl/pll_clk_supervisor.sv - PLL lock qualification, output-clock frequency check and reset sequencing
module pll_clk_supervisor #(
  parameter int PLL_RST_CYC = 16,
  parameter int LOCK_FILTER = 1024,
  parameter int WINDOW      = 12500,
  parameter int EXP_EDGES   = 300,
  parameter int TOL         = 3,
  parameter int RST_HOLD    = 16,
  parameter int CNT_W       = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             outclk_0,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             clk_ok,
  output logic             freq_err,
  output logic [CNT_W-1:0] edge_count,
  output logic [7:0]       lock_loss_cnt
);

  localparam int FILT_W   = $clog2(LOCK_FILTER + 1);
  localparam int STEP_MAX = (PLL_RST_CYC > RST_HOLD) ? PLL_RST_CYC : RST_HOLD;
  localparam int STEP_W   = $clog2(STEP_MAX + 1);
  localparam int LO_INT   = (EXP_EDGES > TOL) ? (EXP_EDGES - TOL) : 0;

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [STEP_W-1:0] PRST_LAST = STEP_W'(PLL_RST_CYC - 1);
  localparam logic [STEP_W-1:0] HOLD_LAST = STEP_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  EDGE_MAX  = '1;
  localparam logic [CNT_W-1:0]  EDGE_LO   = CNT_W'(LO_INT);
  localparam logic [CNT_W-1:0]  EDGE_HI   = CNT_W'(EXP_EDGES + TOL);

  typedef enum logic [2:0] {
    ST_PLLRST,
    ST_WAIT,
    ST_MEAS,
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t            state;
  logic              lock_m, locked_s;
  logic              oclk_m, oclk_s, oclk_d;
  logic              rise;
  logic [STEP_W-1:0] step_cnt;
  logic [FILT_W-1:0] filt_cnt;
  logic [CNT_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_next;
  logic              win_end;
  logic              win_pass;

  // Two-flop synchronizers for both asynchronous inputs, plus a delay flop for outclk edge detection
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_m   <= 1'b0;
      locked_s <= 1'b0;
      oclk_m   <= 1'b0;
      oclk_s   <= 1'b0;
      oclk_d   <= 1'b0;
    end else begin
      lock_m   <= locked;
      locked_s <= lock_m;
      oclk_m   <= outclk_0;
      oclk_s   <= oclk_m;
      oclk_d   <= oclk_s;
    end
  end

  assign rise = oclk_s & ~oclk_d;

  // Edge count including this cycle's edge, and the window-end verdict on it
  always_comb begin
    edge_next = edge_cnt;
    if (rise && (edge_cnt != EDGE_MAX)) edge_next = edge_cnt + 1'b1;
  end

  assign win_end  = (win_cnt == WIN_LAST);
  assign win_pass = (edge_next >= EDGE_LO) && (edge_next <= EDGE_HI);

  // Supervisor FSM: PLL reset, lock filter, measurement, reset hold and run, with registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state         <= ST_PLLRST;
      step_cnt      <= '0;
      filt_cnt      <= '0;
      win_cnt       <= '0;
      edge_cnt      <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      clk_ok        <= 1'b0;
      freq_err      <= 1'b0;
      edge_count    <= '0;
      lock_loss_cnt <= '0;
    end else begin
      case (state)
        ST_PLLRST: begin
          if (step_cnt == PRST_LAST) begin
            state    <= ST_WAIT;
            pll_rst  <= 1'b0;
            filt_cnt <= '0;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (!locked_s) begin
            filt_cnt <= '0;
          end else if (filt_cnt == FILT_LAST) begin
            state    <= ST_MEAS;
            win_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            filt_cnt <= filt_cnt + 1'b1;
          end
        end
        ST_MEAS, ST_HOLD, ST_RUN: begin
          if (!locked_s) begin
            // Lock loss outranks any window verdict landing on the same cycle
            state    <= ST_WAIT;
            filt_cnt <= '0;
            sys_rst  <= 1'b1;
            clk_ok   <= 1'b0;
            if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 1'b1;
          end else if (win_end && !win_pass) begin
            state      <= ST_PLLRST;
            step_cnt   <= '0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            clk_ok     <= 1'b0;
            freq_err   <= 1'b1;
            edge_count <= edge_next;
          end else begin
            if (win_end) begin
              win_cnt    <= '0;
              edge_cnt   <= '0;
              edge_count <= edge_next;
            end else begin
              win_cnt  <= win_cnt + 1'b1;
              edge_cnt <= edge_next;
            end
            if ((state == ST_MEAS) && win_end) begin
              state    <= ST_HOLD;
              step_cnt <= '0;
            end else if (state == ST_HOLD) begin
              if (step_cnt == HOLD_LAST) begin
                state   <= ST_RUN;
                sys_rst <= 1'b0;
                clk_ok  <= 1'b1;
              end else begin
                step_cnt <= step_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= ST_PLLRST;
      endcase
    end
  end

endmodule
